// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick function for the BRAM port-A arbiter.
package mem_arb_pkg;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MAX_REQ    = 4;

    typedef struct packed {
        logic [BYTE_LANES-1:0] we;
        logic [WORD_W-1:0]     addr;
        logic [WORD_W-1:0]     wdata;
    } mem_req_t;

    // One-hot grant to the first requester at or after ptr, modulo n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [1:0]         ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [1:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 2'((32'(ptr) + k) % n);
            if (k < n && !found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Shift pipe of one-hot requester tags; the last stage marks which requester owns doutA.
module rd_tag_pipe #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] tag_in,
    output logic [NUM_REQ-1:0] tag_out
);

    logic [RD_LAT-1:0][NUM_REQ-1:0] pipe;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '0;
        end else begin
            for (int unsigned k = RD_LAT - 1; k > 0; k--) begin
                pipe[k] <= pipe[k-1];
            end
            pipe[0] <= tag_in;
        end
    end

    assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between NUM_REQ requesters,
// with burst lock and tagged read-data return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [4*NUM_REQ-1:0]    we,
    input  logic [32*NUM_REQ-1:0]   addr,
    input  logic [32*NUM_REQ-1:0]   wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rvalid,
    output logic [31:0]             rdata,
    output logic                    enA,
    output logic [3:0]              weA,
    output logic [31:0]             addrA,
    output logic [31:0]             dataToA,
    input  logic [31:0]             doutA
);

    localparam int unsigned HC_W = $clog2(MAX_HOLD) + 1;

    logic [1:0]         ptr;
    logic [HC_W-1:0]    hold_cnt;
    logic [MAX_REQ-1:0] pick;
    mem_req_t           req_vec [NUM_REQ];
    mem_req_t           xfer_req;
    logic               xfer;
    logic               lock_sel;
    logic [1:0]         sel;
    logic [NUM_REQ-1:0] rd_push;
    logic               unused_bits;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_vec[i].we    = we[4*i +: 4];
            req_vec[i].addr  = addr[32*i +: 32];
            req_vec[i].wdata = wdata[32*i +: 32];
        end
    end

    assign pick = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
    // Outputs are forced idle while reset is held, even if requests are present.
    assign gnt  = reset_n ? pick[NUM_REQ-1:0] : '0;

    always_comb begin
        xfer     = 1'b0;
        xfer_req = '0;
        lock_sel = 1'b0;
        sel      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                xfer     = 1'b1;
                xfer_req = req_vec[i];
                lock_sel = lock[i];
                sel      = 2'(i);
            end
        end
    end

    assign enA     = xfer;
    assign weA     = xfer_req.we;
    assign addrA   = {xfer_req.addr[31:2], 2'b00};
    assign dataToA = xfer_req.wdata;
    assign unused_bits = ^{pick, xfer_req.addr[1:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (xfer) begin
            if (lock_sel && hold_cnt < HC_W'(MAX_HOLD - 1)) begin
                ptr      <= sel;
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                ptr      <= (sel == 2'(NUM_REQ - 1)) ? 2'd0 : sel + 2'd1;
                hold_cnt <= '0;
            end
        end
    end

    assign rd_push = (xfer && xfer_req.we == '0) ? gnt : '0;

    rd_tag_pipe #(
        .RD_LAT  (RD_LAT),
        .NUM_REQ (NUM_REQ)
    ) u_rd_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .tag_in  (rd_push),
        .tag_out (rvalid)
    );

    assign rdata = (|rvalid) ? doutA : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a (RD_LAT=2, MAX_HOLD=4) and dut_b (RD_LAT=1, MAX_HOLD=1) share stimulus.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req, lock;
    logic [7:0]  we;
    logic [63:0] addr, wdata;
    logic [31:0] doutA;

    logic [1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [31:0] rdata_a, addrA_a, dataToA_a, rdata_b, addrA_b, dataToA_b;
    logic        enA_a, enA_b;
    logic [3:0]  weA_a, weA_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.NUM_REQ(2), .RD_LAT(2), .MAX_HOLD(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
        .enA(enA_a), .weA(weA_a), .addrA(addrA_a), .dataToA(dataToA_a), .doutA(doutA)
    );

    mem_port_arbiter #(.NUM_REQ(2), .RD_LAT(1), .MAX_HOLD(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .enA(enA_b), .weA(weA_b), .addrA(addrA_b), .dataToA(dataToA_b), .doutA(doutA)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    logic [1:0] exp_lock_a [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    initial begin
        reset_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0; doutA = '0;
        step(); #1;
        chk("rst_gnt", gnt_a, 2'b00);
        chk("rst_enA", enA_a, 1'b0);
        chk("rst_weA", weA_a, 4'h0);
        chk("rst_addrA", addrA_a, 32'h0);
        chk("rst_dataToA", dataToA_a, 32'h0);
        chk("rst_rvalid", rvalid_a, 2'b00);
        chk("rst_rdata", rdata_a, 32'h0);

        // Single requester write; low address bits ignored.
        step(); reset_n = 1'b1;
        req = 2'b01; we[3:0] = 4'hF; addr[31:0] = 32'h0000_0004; wdata[31:0] = 32'hDEAD_BEEF;
        #1;
        chk("wr_gnt", gnt_a, 2'b01);
        chk("wr_enA", enA_a, 1'b1);
        chk("wr_weA", weA_a, 4'hF);
        chk("wr_addrA", addrA_a, 32'h0000_0004);
        chk("wr_dataToA", dataToA_a, 32'hDEAD_BEEF);
        step(); addr[31:0] = 32'h0000_0007; #1;
        chk("wr_regnt", gnt_a, 2'b01);
        chk("wr_addr_lsb", addrA_a, 32'h0000_0004);
        chk("wr_no_rvalid", rvalid_a, 2'b00);

        // Grant requester 1 once so the pointer returns to 0.
        step(); req = 2'b10; we = 8'hFF; wdata[63:32] = 32'hCAFE_0001; addr[63:32] = 32'h10; #1;
        chk("r1_gnt", gnt_a, 2'b10);
        chk("r1_dataToA", dataToA_a, 32'hCAFE_0001);
        chk("r1_addrA", addrA_a, 32'h10);

        // Plain round robin, ptr wraps 1 -> 0.
        req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            chk("rr_alt", gnt_a, (k % 2 == 1) ? 2'b10 : 2'b01);
        end

        // Lock on requester 0: held for MAX_HOLD grants in dut_a, ignored in dut_b.
        lock = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            chk("lock_a", gnt_a, exp_lock_a[k]);
            chk("lock_b_hold1", gnt_b, (k % 2 == 1) ? 2'b10 : 2'b01);
        end
        step(); lock = 2'b00; req = 2'b00; #1;
        chk("idle_gnt", gnt_a, 2'b00);
        chk("idle_enA", enA_a, 1'b0);

        // Requester 1 read, latency 2 in dut_a and 1 in dut_b.
        step(); req = 2'b10; we = 8'h0F; addr[63:32] = 32'h0000_0008; #1;
        chk("rd_gnt", gnt_a, 2'b10);
        chk("rd_weA", weA_a, 4'h0);
        chk("rd_addrA", addrA_a, 32'h0000_0008);
        step(); req = 2'b00; doutA = 32'h1234_5678; #1;
        chk("rd_t1_rvalid_a", rvalid_a, 2'b00);
        chk("rd_t1_rvalid_b", rvalid_b, 2'b10);
        chk("rd_t1_rdata_b", rdata_b, 32'h1234_5678);
        step(); #1;
        chk("rd_t2_rvalid_a", rvalid_a, 2'b10);
        chk("rd_t2_rdata_a", rdata_a, 32'h1234_5678);
        chk("rd_t2_rvalid_b", rvalid_b, 2'b00);
        step(); #1;
        chk("rd_t3_rvalid_a", rvalid_a, 2'b00);
        chk("rd_t3_rdata_a", rdata_a, 32'h0);

        // Back-to-back reads R0, R1, R0.
        we = 8'h00;
        step(); req = 2'b01; doutA = 32'hA0; #1;
        chk("b2b_g0", gnt_a, 2'b01);
        step(); req = 2'b10; doutA = 32'hA1; #1;
        chk("b2b_g1", gnt_a, 2'b10);
        chk("b2b_b1", rvalid_b, 2'b01);
        step(); req = 2'b01; doutA = 32'hA2; #1;
        chk("b2b_g2", gnt_a, 2'b01);
        chk("b2b_a2", rvalid_a, 2'b01);
        chk("b2b_a2_data", rdata_a, 32'hA2);
        chk("b2b_b2", rvalid_b, 2'b10);
        step(); req = 2'b00; doutA = 32'hA3; #1;
        chk("b2b_a3", rvalid_a, 2'b10);
        chk("b2b_a3_data", rdata_a, 32'hA3);
        chk("b2b_b3", rvalid_b, 2'b01);
        step(); doutA = 32'hA4; #1;
        chk("b2b_a4", rvalid_a, 2'b01);
        step(); #1;
        chk("b2b_a5", rvalid_a, 2'b00);

        // Read in flight discarded by a reset pulse; pointer returns to 0.
        step(); req = 2'b01; #1;
        chk("rst_rd_gnt", gnt_a, 2'b01);
        step(); reset_n = 1'b0; req = 2'b11; #1;
        chk("inrst_gnt", gnt_a, 2'b00);
        chk("inrst_enA", enA_a, 1'b0);
        chk("inrst_rvalid_b", rvalid_b, 2'b00);
        step(); reset_n = 1'b1; we = 8'hFF; #1;
        chk("postrst_ptr0", gnt_a, 2'b01);
        chk("postrst_rvalid_a", rvalid_a, 2'b00);
        step(); req = 2'b00; #1;
        chk("postrst_rvalid_a2", rvalid_a, 2'b00);
        chk("postrst_rvalid_b", rvalid_b, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
